// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: PC, one-deep request/response buffer, decode handshake.
// Optional MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VEC and are reported.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef MISALIGN_TRAP_EN
    output logic        misalign,
    output logic [31:0] misalign_addr,
`endif
    output logic [31:0] pc
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DELIVER
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_n;
    logic        drop, drop_n;
    logic        capture;
    logic        req_v, ifv;
    logic [31:0] target;

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |redirect_pc[1:0];
    assign target     = misaligned ? TRAP_VEC : redirect_pc;
`else
    logic unused_lo;
    assign unused_lo = ^redirect_pc[1:0];
    assign target    = {redirect_pc[31:2], 2'b00};
`endif

    always_comb begin
        state_n = state;
        pc_n    = pc;
        drop_n  = drop;
        capture = 1'b0;
        req_v   = 1'b0;
        ifv     = 1'b0;
        case (state)
            S_REQ: begin
                req_v = !redirect_valid;
                if (redirect_valid) begin
                    pc_n = target;
                end else if (imem_req_ready) begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (drop || redirect_valid) begin
                        drop_n  = 1'b0;
                        state_n = S_REQ;
                        if (redirect_valid) pc_n = target;
                    end else begin
                        capture = 1'b1;
                        state_n = S_DELIVER;
                    end
                end else if (redirect_valid) begin
                    // outstanding response now belongs to the wrong path
                    pc_n   = target;
                    drop_n = 1'b1;
                end
            end
            S_DELIVER: begin
                ifv = !redirect_valid;
                if (redirect_valid) begin
                    pc_n    = target;
                    state_n = S_REQ;
                end else if (if_ready) begin
                    pc_n    = pc + 32'd4;
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            drop     <= 1'b0;
            if_pc    <= 32'd0;
            if_instr <= 32'd0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            drop  <= drop_n;
            if (capture) begin
                if_pc    <= pc;
                if_instr <= imem_rsp_data;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign      <= 1'b0;
            misalign_addr <= 32'd0;
        end else begin
            misalign <= redirect_valid && misaligned;
            if (redirect_valid && misaligned) misalign_addr <= redirect_pc;
        end
    end
`endif

    // reset holds state at REQ, so gate the request explicitly
    assign imem_req_valid = req_v && !rst;
    assign if_valid       = ifv && !rst;
    assign imem_addr      = pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Cycle-by-cycle vector bench for fetch_ctrl.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
    logic [31:0] misalign_addr;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk(clk),
        .rst(rst),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
`ifdef MISALIGN_TRAP_EN
        .misalign(misalign),
        .misalign_addr(misalign_addr),
`endif
        .pc(pc)
    );

    typedef struct {
        logic        r;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ifr;
        logic        rdv;
        logic [31:0] rdp;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_ifpc;
        logic [31:0] e_instr;
        logic        cif;
        logic        e_mis;
    } vec_t;

    localparam int N = 44;
    vec_t tv[N];

    function automatic vec_t v(
        input logic r, rdy, rv, input logic [31:0] rd,
        input logic ifr, rdv, input logic [31:0] rdp,
        input logic er, input logic [31:0] ea,
        input logic ev, input logic [31:0] ep, ei,
        input logic cif, em);
        vec_t t;
        t.r = r; t.rdy = rdy; t.rv = rv; t.rd = rd;
        t.ifr = ifr; t.rdv = rdv; t.rdp = rdp;
        t.e_req = er; t.e_addr = ea; t.e_ifv = ev;
        t.e_ifpc = ep; t.e_instr = ei;
        t.cif = cif; t.e_mis = em;
        return t;
    endfunction

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        localparam logic [31:0] A0 = 32'h0000_0A00, A1 = 32'h0000_0A11;
        localparam logic [31:0] A2 = 32'h0000_0A22, B0 = 32'h0000_0B00;
        localparam logic [31:0] C0 = 32'h0000_0C00, D0 = 32'h0000_0D00;
        localparam logic [31:0] E0 = 32'h0000_0E00, F0 = 32'h0000_0F00;
        localparam logic [31:0] BAD = 32'hBAD0_BAD0, DEAD = 32'hDEAD_BEEF;
        localparam logic [31:0] TOP = 32'hFFFF_FFFC;

        //        r rdy rv rd   ifr rdv rdp        er ea        ev ep   ei  cif em
        tv[0]  = v(1, 1, 0, 0,    0, 0, 0,          0, 0,        0, 0,   0,  1, 0);
        tv[1]  = v(0, 1, 0, 0,    0, 0, 0,          1, 0,        0, 0,   0,  0, 0);
        tv[2]  = v(0, 1, 1, A0,   0, 0, 0,          0, 0,        0, 0,   0,  0, 0);
        tv[3]  = v(0, 1, 0, 0,    1, 0, 0,          0, 0,        1, 0,   A0, 0, 0);
        tv[4]  = v(0, 1, 0, 0,    1, 0, 0,          1, 4,        0, 0,   0,  0, 0);
        tv[5]  = v(0, 1, 1, A1,   1, 0, 0,          0, 4,        0, 0,   0,  0, 0);
        tv[6]  = v(0, 1, 0, 0,    1, 0, 0,          0, 4,        1, 4,   A1, 0, 0);
        tv[7]  = v(0, 1, 0, 0,    1, 0, 0,          1, 8,        0, 0,   0,  0, 0);
        tv[8]  = v(0, 1, 1, A2,   0, 0, 0,          0, 8,        0, 0,   0,  0, 0);
        for (int i = 9; i < 14; i++)
            tv[i] = v(0, 1, 1, BAD, 0, 0, 0,        0, 8,        1, 8,   A2, 0, 0);
        tv[14] = v(0, 1, 0, 0,    1, 0, 0,          0, 8,        1, 8,   A2, 0, 0);
        tv[15] = v(0, 1, 0, 0,    0, 0, 0,          1, 32'hC,    0, 0,   0,  0, 0);
        tv[16] = v(0, 1, 0, 0,    0, 1, 32'h200,    0, 32'hC,    0, 0,   0,  0, 0);
        tv[17] = v(0, 1, 0, 0,    0, 0, 0,          0, 32'h200,  0, 0,   0,  0, 0);
        tv[18] = v(0, 1, 1, DEAD, 1, 0, 0,          0, 32'h200,  0, 0,   0,  0, 0);
        tv[19] = v(0, 1, 0, 0,    1, 0, 0,          1, 32'h200,  0, 0,   0,  0, 0);
        tv[20] = v(0, 1, 1, B0,   0, 0, 0,          0, 32'h200,  0, 0,   0,  0, 0);
        tv[21] = v(0, 1, 0, 0,    1, 0, 0,          0, 32'h200,  1, 32'h200, B0, 0, 0);
        tv[22] = v(0, 1, 0, 0,    0, 1, 32'h10,     0, 32'h204,  0, 0,   0,  0, 0);
        tv[23] = v(0, 1, 0, 0,    0, 0, 0,          1, 32'h10,   0, 0,   0,  0, 0);
        tv[24] = v(0, 1, 1, C0,   0, 0, 0,          0, 32'h10,   0, 0,   0,  0, 0);
        tv[25] = v(0, 1, 0, 0,    1, 1, 32'h300,    0, 32'h10,   0, 0,   0,  0, 0);
        tv[26] = v(0, 0, 0, 0,    1, 0, 0,          1, 32'h300,  0, 0,   0,  0, 0);
        tv[27] = v(0, 1, 0, 0,    1, 0, 0,          1, 32'h300,  0, 0,   0,  0, 0);
        tv[28] = v(0, 1, 1, D0,   1, 0, 0,          0, 32'h300,  0, 0,   0,  0, 0);
        tv[29] = v(0, 1, 0, 0,    1, 0, 0,          0, 32'h300,  1, 32'h300, D0, 0, 0);
        tv[30] = v(0, 1, 0, 0,    0, 1, TOP,        0, 32'h304,  0, 0,   0,  0, 0);
        tv[31] = v(0, 1, 0, 0,    0, 0, 0,          1, TOP,      0, 0,   0,  0, 0);
        tv[32] = v(0, 1, 1, E0,   0, 0, 0,          0, TOP,      0, 0,   0,  0, 0);
        tv[33] = v(0, 1, 0, 0,    1, 0, 0,          0, TOP,      1, TOP, E0, 0, 0);
        tv[34] = v(0, 1, 0, 0,    0, 0, 0,          1, 0,        0, 0,   0,  0, 0);
        tv[35] = v(0, 1, 1, F0,   1, 1, 32'h400,    0, 0,        0, 0,   0,  0, 0);
        tv[36] = v(0, 0, 0, 0,    0, 0, 0,          1, 32'h400,  0, 0,   0,  0, 0);
        tv[37] = v(0, 0, 0, 0,    0, 1, 32'h102,    0, 32'h400,  0, 0,   0,  0, 0);
        tv[38] = v(0, 1, 0, 0,    0, 0, 0,          1, 32'h100,  0, 0,   0,  0, 1);
        tv[39] = v(1, 1, 1, BAD,  0, 0, 0,          0, 0,        0, 0,   0,  1, 0);
        tv[40] = v(0, 0, 1, BAD,  0, 0, 0,          1, 0,        0, 0,   0,  0, 0);
        tv[41] = v(0, 1, 0, 0,    0, 0, 0,          1, 0,        0, 0,   0,  0, 0);
        tv[42] = v(0, 1, 1, 32'h13, 0, 0, 0,        0, 0,        0, 0,   0,  0, 0);
        tv[43] = v(0, 1, 0, 0,    1, 0, 0,          0, 0,        1, 0,   32'h13, 0, 0);

        rst = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'd0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;

        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            rst = tv[i].r;
            imem_req_ready = tv[i].rdy;
            imem_rsp_valid = tv[i].rv;
            imem_rsp_data = tv[i].rd;
            if_ready = tv[i].ifr;
            redirect_valid = tv[i].rdv;
            redirect_pc = tv[i].rdp;
            #1;
            chk("req_valid", i, {31'd0, imem_req_valid}, {31'd0, tv[i].e_req});
            chk("imem_addr", i, imem_addr, tv[i].e_addr);
            chk("pc", i, pc, tv[i].e_addr);
            chk("if_valid", i, {31'd0, if_valid}, {31'd0, tv[i].e_ifv});
            if (tv[i].e_ifv || tv[i].cif) begin
                chk("if_pc", i, if_pc, tv[i].e_ifpc);
                chk("if_instr", i, if_instr, tv[i].e_instr);
            end
`ifdef MISALIGN_TRAP_EN
            chk("misalign", i, {31'd0, misalign}, {31'd0, tv[i].e_mis});
            if (tv[i].e_mis)
                chk("misalign_addr", i, misalign_addr, 32'h102);
            if (tv[i].r)
                chk("misalign_addr_rst", i, misalign_addr, 32'd0);
`endif
        end

        // decode stall while a redirect arrives: squash without a handshake
        @(negedge clk);
        if_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        chk("seq_req", 100, {31'd0, imem_req_valid}, 32'd1);
        chk("seq_addr", 100, imem_addr, 32'h4);
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'h1234_5678;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        #1;
        chk("seq_hold_valid", 101, {31'd0, if_valid}, 32'd1);
        chk("seq_hold_instr", 101, if_instr, 32'h1234_5678);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0800;
        #1;
        chk("seq_squash", 102, {31'd0, if_valid}, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("seq_redir_req", 103, {31'd0, imem_req_valid}, 32'd1);
        chk("seq_redir_addr", 103, imem_addr, 32'h800);
        chk("seq_no_ifv", 103, {31'd0, if_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequences the program counter through instruction memory for the RISC-V core.
- Holds the fetch PC, issues one request at a time over a valid/ready handshake, buffers the returned word, and presents it to decode over a second valid/ready handshake.
- Accepts branch/jump/trap redirects from execute and squashes wrong-path fetches.
- Replaces the free-running pc/pc_next pairing with a stall- and latency-tolerant front end.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- TRAP_VEC, 32'h0000_0100, redirect target on misaligned redirect (used only with MISALIGN_TRAP_EN).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  32  fetch address, always equals pc
- imem_rsp_valid  input  1  response word valid, one cycle per accepted request
- imem_rsp_data  input  32  instruction word
- if_valid  output  1  instruction to decode valid
- if_ready  input  1  decode accepts instruction
- if_pc  output  32  address of presented instruction
- if_instr  output  32  presented instruction
- redirect_valid  input  1  single-cycle redirect pulse from execute
- redirect_pc  input  32  redirect target
- pc  output  32  current fetch PC register

Behaviour:
- Reset (async, immediate):
  - state=REQ, pc=RESET_PC, if_pc=0, if_instr=0, drop=0.
  - All valids low while rst is high.
  - First request is asserted in the first cycle after rst falls.
- States: REQ, WAIT, DELIVER. imem_addr = pc, combinational.
- REQ:
  - imem_req_valid = !redirect_valid.
  - redirect_valid: pc<=redirect_pc, stay REQ; no request is accepted that cycle.
  - Else imem_req_ready: go to WAIT.
- WAIT:
  - No request asserted.
  - imem_rsp_valid with drop=0 and no redirect: if_instr<=imem_rsp_data, if_pc<=pc, go to DELIVER.
  - imem_rsp_valid with drop=1 or redirect_valid: discard word, drop<=0, go to REQ. On redirect also pc<=redirect_pc.
  - redirect_valid without rsp: pc<=redirect_pc, drop<=1, stay WAIT.
- DELIVER:
  - if_valid = !redirect_valid.
  - redirect_valid: squash, pc<=redirect_pc, go to REQ. A handshake in that cycle does not count.
  - Else if_ready: pc<=pc+4, go to REQ.
- imem_rsp_valid is ignored in REQ and DELIVER. A late response after reset is ignored because state is REQ.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
- Without the feature, redirect_pc[1:0] is forced to 2'b00.
- Latency: zero-wait memory (rsp the cycle after accept) with if_ready high gives 3 cycles per instruction.
- Redirect to first request at the new PC is 1 cycle.
- Redirect during a stall (if_ready low) is accepted at any time.
- if_pc and if_instr are stable while if_valid is high and if_ready is low.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A redirect with redirect_pc[1:0]!=0 loads pc<=TRAP_VEC instead.
  - misalign (output, 1) pulses high for one cycle, registered, the cycle after the redirect.
  - misalign_addr (output, 32) captures redirect_pc and holds it until the next misaligned redirect.
  - Both reset to 0.
- Undefined: both ports are absent and low bits are masked as above.

Test Plan:
- Reset release, memory always ready, rsp 1 cycle after accept, if_ready=1 -> imem_addr sequence 0x0,0x4,0x8; if_valid every 3rd cycle with if_pc matching.
- if_ready=0 for 5 cycles in DELIVER -> if_valid held, if_instr/if_pc stable, no new request, pc unchanged.
- redirect_valid with redirect_pc=0x200 while in WAIT, response arrives 2 cycles later -> response discarded, next imem_addr=0x200, no if_valid for the old word.
- redirect_valid in same cycle as if_valid&&if_ready at pc 0x10 -> if_valid low that cycle, next request 0x(target), not 0x14.
- pc=0xFFFF_FFFC delivered and accepted -> next imem_addr=0x0000_0000.
- MISALIGN_TRAP_EN: redirect_pc=0x102 -> next imem_addr=TRAP_VEC, misalign pulses once, misalign_addr=0x102. Without the macro the same stimulus fetches 0x100.
- Assert rst mid-WAIT -> outputs return to reset values immediately, stale rsp ignored, first request to RESET_PC.
